// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: state encoding and default program bounds,
// so the fetch ROM, the sequencer and the bench agree on the same address range.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int          DEFAULT_PC_WIDTH     = 32;
  localparam int          DEFAULT_OFFSET_WIDTH = 16;
  localparam int unsigned DEFAULT_RESET_PC     = 0;
  localparam int unsigned DEFAULT_LAST_PC      = 5;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/fetch bundle between the PC sequencer (master) and its surrounding pipeline (slave).
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int PC_WIDTH     = DEFAULT_PC_WIDTH,
  parameter int OFFSET_WIDTH = DEFAULT_OFFSET_WIDTH
);

  logic                    stall;
  logic                    branch_taken;
  logic [OFFSET_WIDTH-1:0] branch_offset;
  logic [PC_WIDTH-1:0]     pc;
  logic [PC_WIDTH-1:0]     pc_plus1;
  logic                    fetch_valid;
  logic                    halted;

  modport master (
    input  stall,
    input  branch_taken,
    input  branch_offset,
    output pc,
    output pc_plus1,
    output fetch_valid,
    output halted
  );

  modport slave (
    output stall,
    output branch_taken,
    output branch_offset,
    input  pc,
    input  pc_plus1,
    input  fetch_valid,
    input  halted
  );

endinterface

// File: rtl/pc_sequencer_next_calc.sv
// Combinational next-PC selection: sign-extended branch target, stall hold or sequential
// increment, plus a flag telling whether the chosen PC leaves the program range.
module pc_next_calc
  import pc_sequencer_pkg::*;
#(
  parameter int          PC_WIDTH     = DEFAULT_PC_WIDTH,
  parameter int          OFFSET_WIDTH = DEFAULT_OFFSET_WIDTH,
  parameter int unsigned LAST_PC      = DEFAULT_LAST_PC
) (
  input  logic [PC_WIDTH-1:0]     pc,
  input  logic [PC_WIDTH-1:0]     pc_plus1,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [OFFSET_WIDTH-1:0] branch_offset,
  output logic [PC_WIDTH-1:0]     next_pc,
  output logic                    out_of_range
);

  logic [PC_WIDTH-1:0] offset_sext;
  logic [PC_WIDTH-1:0] branch_target;

  generate
    if (PC_WIDTH > OFFSET_WIDTH) begin : g_sext
      assign offset_sext = {{(PC_WIDTH-OFFSET_WIDTH){branch_offset[OFFSET_WIDTH-1]}}, branch_offset};
    end else begin : g_trunc
      assign offset_sext = branch_offset[PC_WIDTH-1:0];
    end
  endgenerate

  // Target is relative to the following word; wraps modulo 2^PC_WIDTH.
  assign branch_target = pc_plus1 + offset_sext;

  always_comb begin
    next_pc = pc_plus1;
    if (branch_taken) begin
      next_pc = branch_target;
    end else if (stall) begin
      next_pc = pc;
    end
  end

  // A wrapped negative target lands high and is caught by the same unsigned compare.
  assign out_of_range = (next_pc > PC_WIDTH'(LAST_PC));

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage ahead of the fetch ROM: one boot bubble, then sequential fetch with
// branch/stall handling, halting for good once the PC would leave the program.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int          PC_WIDTH     = DEFAULT_PC_WIDTH,
  parameter int unsigned RESET_PC     = DEFAULT_RESET_PC,
  parameter int unsigned LAST_PC      = DEFAULT_LAST_PC,
  parameter int          OFFSET_WIDTH = DEFAULT_OFFSET_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.master bus
);

  pc_state_e           state_reg;
  pc_state_e           state_next;
  logic [PC_WIDTH-1:0] pc_reg;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] pc_plus1;
  logic [PC_WIDTH-1:0] calc_pc;
  logic                calc_out_of_range;

  assign pc_plus1 = pc_reg + PC_WIDTH'(1);

  pc_next_calc #(
    .PC_WIDTH     (PC_WIDTH),
    .OFFSET_WIDTH (OFFSET_WIDTH),
    .LAST_PC      (LAST_PC)
  ) u_next_calc (
    .pc            (pc_reg),
    .pc_plus1      (pc_plus1),
    .stall         (bus.stall),
    .branch_taken  (bus.branch_taken),
    .branch_offset (bus.branch_offset),
    .next_pc       (calc_pc),
    .out_of_range  (calc_out_of_range)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= BOOT;
      pc_reg    <= PC_WIDTH'(RESET_PC);
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      BOOT: state_next = RUN;
      RUN: begin
        // Running off the end freezes the PC on the last word that was fetched.
        if (calc_out_of_range) begin
          state_next = HALT;
        end else begin
          pc_next = calc_pc;
        end
      end
      HALT: state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  assign bus.pc          = pc_reg;
  assign bus.pc_plus1    = pc_plus1;
  assign bus.fetch_valid = (state_reg == RUN);
  assign bus.halted      = (state_reg == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random branch/stall/reset traffic,
// compared every cycle against a simple behavioural PC model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int          PW      = 32;
  localparam int          OW      = 16;
  localparam int unsigned LAST    = DEFAULT_LAST_PC;
  localparam int unsigned BOOT_PC = DEFAULT_RESET_PC;

  logic clk;
  logic rst;

  pc_sequencer_if #(.PC_WIDTH(PW), .OFFSET_WIDTH(OW)) bus ();

  pc_sequencer #(
    .PC_WIDTH     (PW),
    .RESET_PC     (BOOT_PC),
    .LAST_PC      (LAST),
    .OFFSET_WIDTH (OW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Behavioural model: where the PC is and which phase the sequencer is in.
  longint unsigned m_pc;
  bit              m_booting;
  bit              m_halted;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pc"},          64'(bus.pc),          64'(m_pc));
    check({tag, ".pc_plus1"},    64'(bus.pc_plus1),    64'(32'(m_pc + 1)));
    check({tag, ".fetch_valid"}, 64'(bus.fetch_valid), 64'(!m_booting && !m_halted));
    check({tag, ".halted"},      64'(bus.halted),      64'(m_halted));
  endtask

  task automatic model_reset();
    m_pc      = BOOT_PC;
    m_booting = 1'b1;
    m_halted  = 1'b0;
  endtask

  task automatic model_clock(input bit s, input bit b, input logic [OW-1:0] off);
    longint target;
    longint unsigned nxt;
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (!m_halted) begin
      target = longint'(m_pc) + 1 + longint'($signed(off));
      if (b)      nxt = 64'(32'(target));
      else if (s) nxt = m_pc;
      else        nxt = 64'(32'(m_pc + 1));
      if (nxt > LAST) m_halted = 1'b1;
      else            m_pc = nxt;
    end
  endtask

  // One clock: drive inputs, model the edge, then compare on the falling edge.
  task automatic cycle(input bit s, input bit b, input logic [OW-1:0] off, input string tag);
    bus.stall         = s;
    bus.branch_taken  = b;
    bus.branch_offset = off;
    @(posedge clk);
    model_clock(s, b, off);
    @(negedge clk);
    cyc++;
    $display("[TB] %s cyc=%0d st=%b br=%b off=%h -> pc=%0h fv=%b halted=%b",
             tag, cyc, s, b, off, bus.pc, bus.fetch_valid, bus.halted);
    check_outputs(tag);
  endtask

  // Pulse rst between edges and confirm the outputs clear before any clock arrives.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    $display("[TB] %s async reset -> pc=%0h fv=%b halted=%b",
             tag, bus.pc, bus.fetch_valid, bus.halted);
    check_outputs(tag);
    #1 rst = 1'b0;
  endtask

  task automatic run_to_pc(input longint unsigned target, input string tag);
    int n;
    n = 0;
    while (!(m_pc == target && !m_booting) && n < 20) begin
      cycle(1'b0, 1'b0, '0, tag);
      n++;
    end
    check({tag, ".reach_bound"}, 64'(n < 20), 64'(1));
  endtask

  initial begin
    rst               = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_outputs("reset");

    // Straight-line run through the whole program, then halt.
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, '0, "seq");
    check("seq.halt_pc", 64'(bus.pc), 64'(LAST));

    // Forward branch skipping one word.
    async_reset("br_fwd");
    run_to_pc(2, "br_fwd");
    cycle(1'b0, 1'b1, 16'h0001, "br_fwd");
    check("br_fwd.target", 64'(bus.pc), 64'd4);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, "br_fwd");

    // Three-cycle stall at pc=1.
    async_reset("stall");
    run_to_pc(1, "stall");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, "stall");
    check("stall.hold", 64'(bus.pc), 64'd1);
    cycle(1'b0, 1'b0, '0, "stall");
    check("stall.release", 64'(bus.pc), 64'd2);

    // Branch wins over a simultaneous stall.
    run_to_pc(3, "br_stall");
    cycle(1'b1, 1'b1, 16'hFFFD, "br_stall");
    check("br_stall.target", 64'(bus.pc), 64'd1);

    // Wrapping negative target halts; inputs ignored afterwards.
    async_reset("wrap");
    run_to_pc(0, "wrap");
    cycle(1'b0, 1'b1, 16'hFFF0, "wrap");
    check("wrap.halted", 64'(bus.halted), 64'd1);
    for (int i = 0; i < 4; i++) cycle(1'(i), 1'b1, 16'h0001, "wrap");

    // Async reset mid-run and in HALT.
    async_reset("rst_mid");
    run_to_pc(4, "rst_mid");
    cycle(1'b0, 1'b1, 16'h0000, "rst_mid");
    async_reset("rst_mid");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, "rst_mid");
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, "rst_halt");
    async_reset("rst_halt");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, "rst_halt");

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      bit s, b;
      logic [OW-1:0] off;
      int v;
      s = ($urandom_range(0, 9) < 3);
      b = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 9) == 0) begin
        off = OW'($urandom);
      end else begin
        v   = int'($urandom_range(0, 12)) - 6;
        off = OW'(v);
      end
      if ($urandom_range(0, 19) == 0 || (m_halted && $urandom_range(0, 3) == 0))
        async_reset("rand");
      cycle(s, b, off, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
